// File: rtl/fetch_issue_ctrl.sv
// fetch_issue_ctrl: fetch-buffer occupancy tracking and dual-slot issue control.
// Takes in icache fetch packets of 1 or 2 instructions and grants up to two
// dequeues per cycle to decode. An oldest entry that carries a fetch exception
// parks the FSM in DRAIN, where it waits for the redirect flush.
// Optional macro FETCH_ISSUE_PERF_EN adds the dual-issue and bubble counters.
// When the macro is absent, both counter outputs are tied to 0.
module fetch_issue_ctrl #(
    parameter int DEPTH  = 14,
    parameter int MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        enq_valid,
    input  logic        enq_two,
    input  logic        head_valid0,
    input  logic        head_valid1,
    input  logic        head_excp0,
    input  logic        head_brtaken0,
    input  logic        dec_ready,
    output logic        if0,
    output logic        if1,
    output logic        fetch_ready,
    output logic [3:0]  count,
    output logic [1:0]  state,
    output logic [31:0] perf_dual,
    output logic [31:0] perf_bubble
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, RECOVER = 2'b11} state_t;
    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [4:0] sum;
    logic       run, enq;
    // Grants, enqueue acceptance, next occupancy and next FSM state
    always_comb begin
        run         = state_q == RUN;
        if0         = run & ~stall & dec_ready & (count_q != 4'd0) & head_valid0;
        if1         = if0 & (count_q >= 4'd2) & head_valid1 & ~head_excp0 & ~head_brtaken0;
        fetch_ready = run & ({1'b0, count_q} <= 5'(DEPTH - MARGIN));
        enq         = enq_valid & fetch_ready & ~stall;
        sum         = {1'b0, count_q} + (enq ? (enq_two ? 5'd2 : 5'd1) : 5'd0)
                      - {4'd0, if0} - {4'd0, if1};
        count_d     = flush ? 4'd0 : sum[3:0];
        state_d     = flush ? RECOVER :
                      (state_q == IDLE || state_q == RECOVER) ? RUN :
                      (if0 & head_excp0) ? DRAIN : state_q;
    end
    // State and occupancy registers; reset wins over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
    assign count = count_q;
    assign state = state_q;
`ifdef FETCH_ISSUE_PERF_EN
    logic [31:0] perf_dual_q, perf_bubble_q;
    // Free-running event counters; flush leaves them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual_q   <= 32'd0;
            perf_bubble_q <= 32'd0;
        end else begin
            perf_dual_q   <= perf_dual_q + {31'd0, if1};
            perf_bubble_q <= perf_bubble_q + {31'd0, run & dec_ready & (count_q == 4'd0)};
        end
    end
    assign perf_dual   = perf_dual_q;
    assign perf_bubble = perf_bubble_q;
`else
    assign perf_dual   = 32'd0;
    assign perf_bubble = 32'd0;
`endif
endmodule

// File: doc/fetch_issue_ctrl.md
FETCH_ISSUE_CTRL -- requirements
Module: fetch_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 14, meaning usable fetch-buffer entry capacity.
REQ-002 SHALL have parameter MARGIN, default 2, meaning free entries required before fetch is accepted.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, meaning pipeline redirect; the buffer contents are discarded.
REQ-006 SHALL have port stall, input, 1, meaning backend stall; freezes enqueue and dequeue.
REQ-007 SHALL have port enq_valid, input, 1, meaning an icache fetch packet is presented.
REQ-008 SHALL have port enq_two, input, 1, meaning the packet holds 2 instructions (0 = 1 instruction).
REQ-009 SHALL have port head_valid0/head_valid1, input, 1 each, meaning valid bit of the oldest/second-oldest entry.
REQ-010 SHALL have port head_excp0, input, 1, meaning the oldest entry carries a fetch exception.
REQ-011 SHALL have port head_brtaken0, input, 1, meaning the oldest entry is predicted taken.
REQ-012 SHALL have port dec_ready, input, 1, meaning decode accepts instructions this cycle.
REQ-013 SHALL have port if0/if1, output, 1 each, meaning dequeue grant for slot 0/slot 1.
REQ-014 SHALL have port fetch_ready, output, 1, meaning the buffer accepts an enqueue this cycle.
REQ-015 SHALL have port count, output, 4, meaning the current occupancy.
REQ-016 SHALL have port state, output, 2, meaning FSM state: IDLE=00, RUN=01, DRAIN=10, RECOVER=11.
REQ-017 SHALL have port perf_dual, output, 32, meaning cycles with a dual issue.
REQ-018 SHALL have port perf_bubble, output, 32, meaning RUN cycles with dec_ready=1 and count=0.

Function
REQ-019 if0 SHALL be 1 only when state=RUN, !stall, dec_ready, count>=1 and head_valid0.
REQ-020 if1 SHALL equal if0 & (count>=2) & head_valid1 & !head_excp0 & !head_brtaken0.
REQ-021 fetch_ready SHALL equal (state=RUN) & (count <= DEPTH-MARGIN); it does not depend on stall.
REQ-022 An enqueue SHALL be accepted when enq_valid & fetch_ready & !stall; it adds enq_two?2:1 entries.
REQ-023 The dequeue amount SHALL be if0+if1.
REQ-024 The next count SHALL be count + enqueue - dequeue, computed at 5 bits; it never exceeds DEPTH and never underflows.
REQ-025 Simultaneous enqueue and dequeue in one cycle SHALL both take effect.
REQ-026 IDLE SHALL go to RUN unconditionally after one cycle; no grants and fetch_ready=0 in IDLE.
REQ-027 In RUN, a grant with if0=1 and head_excp0=1 SHALL move the FSM to DRAIN.
REQ-028 DRAIN SHALL hold if0=if1=0 and fetch_ready=0 until flush.
REQ-029 flush in any state SHALL, at the next edge, set state=RECOVER and count=0.
REQ-030 flush SHALL drop any same-cycle enqueue and dequeue effect on count.
REQ-031 RECOVER SHALL last exactly one cycle, then go to RUN (or back to RECOVER if flush is high again), with no grants and fetch_ready=0.
REQ-032 In RUN, stall=1 SHALL hold count and state unchanged.

Reset
REQ-033 rst SHALL have priority over flush; at the edge it sets state=IDLE, count=0, perf_dual=0 and perf_bubble=0, so all outputs read 0 the following cycle.
REQ-034 rst asserted mid-operation (any state, any count) SHALL produce the same result as power-up reset.

Configuration
REQ-035 The feature SHALL be controlled by macro FETCH_ISSUE_PERF_EN.
REQ-036 When FETCH_ISSUE_PERF_EN is defined, perf_dual SHALL increment on cycles with if1=1 and perf_bubble per REQ-018; both wrap at 2^32 and are not cleared by flush.
REQ-037 When FETCH_ISSUE_PERF_EN is undefined, no counter registers SHALL exist and both outputs SHALL be constant 0.

Verification
REQ-038 Reset release -> state IDLE for 1 cycle, then RUN; count=0; fetch_ready=1.
REQ-039 Starting at count=0, dec_ready=0, apply 6 cycles of enq_valid=1, enq_two=1 -> count 2,4,...,12; fetch_ready goes 0 at count=13 or above (DEPTH=14); no overflow.
REQ-040 count=5, all heads valid, dec_ready=1, enq_two=1 -> if0=if1=1, count stays 5; with head_brtaken0=1 -> if1=0, count becomes 6.
REQ-041 count=3, head_excp0=1, dec_ready=1 -> if0=1, if1=0, next state DRAIN, then grants=0 until flush; flush -> RECOVER, count=0, then RUN.
REQ-042 count=4, stall=1, enq_valid=1, dec_ready=1 -> if0=0, count stays 4; flush together with enq_valid -> count=0.
REQ-043 With the macro on, 10 dual-issue cycles -> perf_dual=10; rst -> 0; with the macro off, the outputs are always 0.
